// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for the parametrised clk_1 FIFO: pointer sizing helper,
// default word width and status-register flag bit positions.
package param_sync_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;

  // Bit positions of the FIFO flags inside the status register
  localparam int unsigned FLAG_EMPTY_BIT = 0;
  localparam int unsigned FLAG_FULL_BIT  = 1;
  localparam int unsigned FLAG_AFULL_BIT = 2;
  localparam int unsigned FLAG_OVF_BIT   = 3;
  localparam int unsigned FLAG_UNF_BIT   = 4;
  localparam int unsigned FLAG_W         = 5;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port, no reset.
module param_sync_fifo_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_1,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples the pre-write contents, so a same-address write never bypasses
  always_ff @(posedge clk_1) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full back-pressure
// and sticky overflow/underflow flags; storage lives in param_sync_fifo_ram.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_LVL = 6
) (
  input  logic                  clk_1,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              loaded_q, loaded_d;
  logic              wr_ok_c, rd_ok_c;
  logic [DATA_W-1:0] ram_rdata;

  // Accept logic, pointer/count advance and flag next-state
  always_comb begin
    rd_ok_c  = rd_en & ~empty_q;
    wr_ok_c  = wr_en & (~full_q | rd_ok_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok_c) wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (rd_ok_c) rd_ptr_d = rd_ptr_q + CNT_W'(1);
    count_d  = count_q + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
    empty_d  = (count_d == '0);
    full_d   = (count_d == CNT_W'(DEPTH));
    afull_d  = (count_d >= CNT_W'(AFULL_LVL));
    dv_d     = rd_ok_c;
    loaded_d = loaded_q | rd_ok_c;
    // A new error in the same cycle as clr_err keeps the flag set
    ovf_d    = (ovf_q & ~clr_err) | (wr_en & ~wr_ok_c);
    unf_d    = (unf_q & ~clr_err) | (rd_en & ~rd_ok_c);
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      loaded_q <= loaded_d;
    end
  end

  param_sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk_1   (clk_1),
    .we_i    (wr_ok_c),
    .waddr_i (wr_ptr_q[PTR_W-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_ok_c),
    .raddr_i (rd_ptr_q[PTR_W-1:0]),
    .rdata_o (ram_rdata)
  );

  // RAM read register is unreset; mask it to zero until the first read after reset
  assign data_out    = loaded_q ? ram_rdata : '0;
  assign data_valid  = dv_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: queue-based reference model, directed
// corner cases plus randomized traffic, decoupled output monitor.
module tb_param_sync_fifo;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned AFULL_LVL = 6;

  logic              clk_1 = 1'b0;
  logic              rst;
  logic              wr_en, rd_en, clr_err;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid, empty, full, almost_full, overflow, underflow;
  logic [3:0]        count;

  param_sync_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk_1 = ~clk_1;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf, m_unf;
  logic [DATA_W-1:0] last_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input logic exp_dv);
    int n;
    n = model_q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= AFULL_LVL));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("data_valid", 32'(data_valid), 32'(exp_dv));
  endtask

  // One clock of stimulus; the reference model decides acceptance from occupancy
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d, input logic c);
    logic rok, wok;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    clr_err = c;
    rok = r && (model_q.size() > 0);
    wok = w && ((model_q.size() < DEPTH) || rok);
    if (rok) exp_q.push_back(model_q.pop_front());
    if (wok) model_q.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wok);
    m_unf = (m_unf && !c) || (r && !rok);
    @(posedge clk_1);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    check_flags(rok);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (model_q.size() > 0 && guard < 64) begin
      step(1'b0, 1'b1, '0, 1'b0);
      guard++;
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    last_out = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    data_in = '0;
    model_reset();

    // Output monitor: every data_valid pulse must match the oldest expected word
    fork
      forever begin
        @(negedge clk_1);
        if (!rst) begin
          if (data_valid) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_valid: data_out 0x%0h with no word expected", data_out);
            end else begin
              logic [DATA_W-1:0] e;
              e = exp_q.pop_front();
              chk("data_out", 32'(data_out), 32'(e));
              last_out = e;
            end
          end else begin
            chk("data_out_hold", 32'(data_out), 32'(last_out));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk_1);
    #1;
    check_flags(1'b0);
    chk("reset_data_out", 32'(data_out), 32'h0);
    rst = 1'b0;

    // Fill 1..8, then overflow with 0xDEAD, then clear the error
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DATA_W'(i), 1'b0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Simultaneous read/write at full, then drain (0x00AA comes out last)
    step(1'b1, 1'b1, 16'h00AA, 1'b0);
    drain();

    // Read+write while empty: write lands, read flagged as underflow
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    // clr_err and a fresh underflow in the same cycle: flag stays set
    step(1'b0, 1'b1, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Wrap-around at occupancy ~3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DATA_W'($urandom), 1'b0);
    drain();

    // Randomized traffic including errors and clears
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom),
           1'($urandom_range(0, 15) == 0));
    end
    drain();

    // Mid-stream reset with count 5, a live data_valid and a sticky error
    step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'(16'h0100 + i), 1'b0);
    step(1'b1, 1'b1, 16'h0200, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_flags(1'b0);
    chk("mid_reset_data_out", 32'(data_out), 32'h0);
    @(posedge clk_1);
    #1;
    rst = 1'b0;

    // Post-reset traffic proves old contents are gone
    step(1'b1, 1'b0, 16'h0F0F, 1'b0);
    step(1'b1, 1'b0, 16'hF0F0, 1'b0);
    drain();

    repeat (2) @(posedge clk_1);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
